lcd_req_arbiter: RTL and testbench
==================================

Name: lcd_req_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one L1602A LCD controller between NREQ requesters.
- Each requester presents an op/data pair. The arbiter grants one requester, drives the controller's op/data/enable inputs, and tracks lcd_rdy through busy and done.
- Returns an accept pulse and a completion pulse per requester.
- Lock input lets a requester keep ownership across a multi-op sequence (e.g. a string write), so its ops are not interleaved with other requesters' ops.

Parameters:
- NREQ, 4, number of requesters (2..8).
- OP_W, 6, width of one op vector; passed through unchanged, not decoded.
- BUSY_TIMEOUT, 64, max cycles after enable for lcd_rdy to fall before error.
- TO_W, 8, timeout counter width; must satisfy 2^TO_W > BUSY_TIMEOUT.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- req  in  NREQ  request per requester; level, held until ack.
- lock  in  NREQ  hold ownership after current op completes.
- req_op  in  NREQ*OP_W  op of requester i at bits [i*OP_W +: OP_W].
- req_data  in  NREQ*8  data of requester i at bits [i*8 +: 8].
- ack  out  NREQ  one-cycle pulse: request latched.
- done  out  NREQ  one-cycle pulse: controller finished the op.
- err  out  1  one-cycle pulse: busy timeout.
- grant  out  NREQ  one-hot current owner; zero when no owner.
- lcd_op  out  OP_W  to controller op_in.
- lcd_data  out  8  to controller data_in.
- lcd_enable  out  1  one-cycle start strobe to controller.
- lcd_rdy  in  1  controller ready; 1 = idle.

Behaviour:
- Reset (async, any state): state=IDLE, owner invalid, lock_hold=0, rr_ptr=NREQ-1 (requester 0 highest priority).
  - Outputs ack, done, err, grant, lcd_op, lcd_data, lcd_enable all go to 0 immediately.
  - Reset mid-operation abandons the op silently; no done or err is issued.
- States:
  - IDLE: arbitration.
  - ISSUE: enable strobe.
  - WAIT_BUSY: wait for lcd_rdy=0.
  - WAIT_DONE: wait for lcd_rdy=1.
- IDLE:
  - If lcd_rdy=1 and a candidate exists, select the winner, register req_op/req_data into lcd_op/lcd_data, pulse ack[winner], set grant, rr_ptr<=winner, go to ISSUE.
  - If lcd_rdy=0, no grant is made.
  - Candidates when lock_hold=1: only the owner.
  - Candidates when lock_hold=0: all req bits, searched from rr_ptr+1 upward, wrapping modulo NREQ.
- ISSUE: lcd_enable=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_BUSY.
  - lcd_enable rises one cycle after ack.
- WAIT_BUSY:
  - If lcd_rdy=0, go to WAIT_DONE.
  - Otherwise increment the counter. When counter==BUSY_TIMEOUT-1 and lcd_rdy is still 1, pulse err, clear grant and lock_hold, go to IDLE.
- WAIT_DONE:
  - On lcd_rdy=1, pulse done[owner] and go to IDLE.
  - On the same edge, lock_hold<=lock[owner].
  - grant stays asserted if lock_hold is set, otherwise it clears.
  - No timeout in this state; controller init ops take ms.
- Lock release:
  - In IDLE with lock_hold=1, if lock[owner]=0 and req[owner]=0, clear lock_hold and grant.
  - Arbitration resumes normally the following cycle.
  - While locked, other requesters wait indefinitely; no starvation guard is required.
- lcd_op/lcd_data hold their last granted values until the next grant. They are stable throughout ISSUE..WAIT_DONE regardless of req_* changes.
- Requester handshake:
  - A requester dropping req before ack is not served.
  - req still high in the cycle after ack is treated as a new request, eligible only after done.
- Exactly one ack per enable, and at most one done or err per ack.
- Simultaneous events:
  - lcd_rdy=0 in IDLE blocks arbitration, e.g. for the controller's own init.
  - req and lock of a non-owner while locked are ignored.
  - Timeout edge with lcd_rdy falling in the same cycle: falling wins; go to WAIT_DONE, no err.

Test Plan:
- Single request: req[0]=1, op=6'b000010, data=8'h41; controller model drops rdy 3 cycles after enable for 20 cycles.
  - Expect ack[0] at cycle T, lcd_enable at T+1, lcd_op/lcd_data=000010/41, and done[0] one cycle after rdy returns.
- Round-robin: req=4'b1111 held continuously with ack'd ops re-requested.
  - Expect grant order 0,1,2,3,0 with one enable per grant.
- Lock: req[2] with lock[2]=1 for three ops while req[1]=1.
  - Expect three consecutive grants to 2, then grant to 1 only after lock[2] and req[2] drop.
- Timeout: model keeps rdy=1 after enable.
  - Expect err pulse exactly BUSY_TIMEOUT cycles after the enable cycle, no done, grant=0, and the next request still served.
- rdy low at idle: hold lcd_rdy=0 with req[3]=1.
  - Expect no ack until rdy=1, then ack[3] the same cycle.
- Reset mid-op: assert rst during WAIT_DONE.
  - Expect all outputs 0 asynchronously, no done, and after release requester 0 has top priority.

Source files
------------

// File: rtl/lcd_req_arbiter.sv
// Round-robin arbiter that shares one L1602A LCD controller between NREQ requesters.
// Grants one op at a time, strobes the controller, and follows lcd_rdy through busy and done.
module lcd_req_arbiter #(
    parameter int NREQ         = 4,
    parameter int OP_W         = 6,
    parameter int BUSY_TIMEOUT = 64,
    parameter int TO_W         = 8,
    localparam int IDX_W       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ*OP_W-1:0] req_op,
    input  logic [NREQ*8-1:0]    req_data,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [NREQ-1:0]      grant,
    output logic [OP_W-1:0]      lcd_op,
    output logic [7:0]           lcd_data,
    output logic                 lcd_enable,
    input  logic                 lcd_rdy
);

    // Handshake: req[i] is a level held until ack[i]. ack[i] is a one-cycle pulse
    // meaning op/data were latched; req[i] still high the cycle after ack[i] is a
    // new request, eligible once done[i] (or err) closes the current op.

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic             lock_hold;
    logic [TO_W-1:0]  to_cnt;

    logic             cand_found;
    logic [IDX_W-1:0] cand_idx;
    logic             lock_release;

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // While locked only the owner may win; otherwise search upward from rr_ptr+1.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        if (lock_hold) begin
            cand_found = req[owner];
            cand_idx   = owner;
        end else begin
            for (int i = 1; i <= NREQ; i++) begin
                if (!cand_found && req[(int'(rr_ptr) + i) % NREQ]) begin
                    cand_found = 1'b1;
                    cand_idx   = IDX_W'((int'(rr_ptr) + i) % NREQ);
                end
            end
        end
    end

    assign lock_release = lock_hold && !lock[owner] && !req[owner];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= IDX_W'(NREQ - 1);
            lock_hold  <= 1'b0;
            to_cnt     <= '0;
            ack        <= '0;
            done       <= '0;
            err        <= 1'b0;
            grant      <= '0;
            lcd_op     <= '0;
            lcd_data   <= '0;
            lcd_enable <= 1'b0;
        end else begin
            ack        <= '0;
            done       <= '0;
            err        <= 1'b0;
            lcd_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (lock_release) begin
                        lock_hold <= 1'b0;
                        grant     <= '0;
                    end else if (lcd_rdy && cand_found) begin
                        lcd_op   <= req_op[cand_idx*OP_W +: OP_W];
                        lcd_data <= req_data[cand_idx*8 +: 8];
                        ack      <= onehot(cand_idx);
                        grant    <= onehot(cand_idx);
                        owner    <= cand_idx;
                        rr_ptr   <= cand_idx;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    lcd_enable <= 1'b1;
                    to_cnt     <= '0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A falling lcd_rdy beats a timeout on the same edge.
                    if (!lcd_rdy) begin
                        state <= WAIT_DONE;
                    end else if (to_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
                        err       <= 1'b1;
                        grant     <= '0;
                        lock_hold <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    // No timeout here: controller init ops can take milliseconds.
                    if (lcd_rdy) begin
                        done      <= onehot(owner);
                        lock_hold <= lock[owner];
                        if (!lock[owner]) begin
                            grant <= '0;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_req_arbiter.sv
// Scoreboard bench for lcd_req_arbiter: directed requester scenarios against a simple
// L1602A controller model; a negedge monitor pops expected ack/done/err events.
module tb_lcd_req_arbiter;

    localparam int NREQ = 4;
    localparam int OP_W = 6;
    localparam int BT   = 64;
    localparam int W    = 23;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      lock;
    logic [NREQ*OP_W-1:0] req_op;
    logic [NREQ*8-1:0]    req_data;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic [NREQ-1:0]      grant;
    logic [OP_W-1:0]      lcd_op;
    logic [7:0]           lcd_data;
    logic                 lcd_enable;
    logic                 lcd_rdy;

    logic rdy_model = 1'b1;
    logic hold_low  = 1'b0;
    logic no_busy   = 1'b0;
    assign lcd_rdy = rdy_model & ~hold_low;

    int          tgt [NREQ] = '{0, 0, 0, 0};
    int          got [NREQ] = '{0, 0, 0, 0};
    int          st  [NREQ] = '{0, 0, 0, 0};
    logic [5:0]  r_op  [NREQ] = '{6'h0, 6'h0, 6'h0, 6'h0};
    logic [7:0]  r_base[NREQ] = '{8'h0, 8'h0, 8'h0, 8'h0};

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int ack_total = 0;
    int done_cnt [NREQ] = '{0, 0, 0, 0};

    lcd_req_arbiter #(.NREQ(NREQ), .OP_W(OP_W), .BUSY_TIMEOUT(BT), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .req_op(req_op),
        .req_data(req_data), .ack(ack), .done(done), .err(err), .grant(grant),
        .lcd_op(lcd_op), .lcd_data(lcd_data), .lcd_enable(lcd_enable), .lcd_rdy(lcd_rdy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- requesters: level req until acked n times ----------------
    always_comb begin
        req      = '0;
        req_op   = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            req[i]              = (tgt[i] != got[i]);
            req_op[i*OP_W +: OP_W] = r_op[i];
            req_data[i*8 +: 8]  = r_base[i] + 8'(got[i] - st[i]);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++)
            if (!rst && ack[i] && tgt[i] != got[i]) got[i] = got[i] + 1;
    end

    // ---------------- controller model: busy 3 cycles after enable, for 20 ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (lcd_enable && !rst && !no_busy) begin
                repeat (3) @(posedge clk);
                #1 rdy_model = 1'b0;
                repeat (20) @(posedge clk);
                #1 rdy_model = 1'b1;
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    function automatic logic [W-1:0] mk(input logic [1:0] k, input int i, input logic [5:0] op,
                                        input logic [7:0] d, input logic [3:0] g);
        return {k, 3'(i), op, d, g};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic pop_cmp(input string name, input logic [W-1:0] obs);
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event %h with empty queue at %0t", name, obs, $time);
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h at %0t", name, obs, e, $time);
            end
        end
    endtask

    task automatic push_op(input int i, input logic [5:0] op, input logic [7:0] d,
                           input logic [3:0] g_after);
        exp_q.push_back(mk(2'd1, i, op, d, 4'(1 << i)));
        exp_q.push_back(mk(2'd2, i, op, d, g_after));
    endtask

    task automatic set_req(input int i, input int n, input logic [5:0] op, input logic [7:0] d);
        st[i]     = got[i];
        r_op[i]   = op;
        r_base[i] = d;
        tgt[i]    = got[i] + n;
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_empty: %0d events still expected at %0t", exp_q.size(), $time);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_grant(input int i, input int budget);
        int n;
        n = 0;
        while (!grant[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_grant", 32'(grant[i]), 32'd1);
    endtask

    // ---------------- monitor ----------------
    logic prev_ack = 1'b0;
    logic r1 = 1'b1, r2 = 1'b1;
    int   en_age = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_ack = 1'b0;
            r1 = 1'b1;
            r2 = 1'b1;
            en_age = 0;
        end else begin
            if (lcd_enable || prev_ack) chk("enable_after_ack", 32'(lcd_enable), 32'(prev_ack));
            en_age = lcd_enable ? 0 : en_age + 1;
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    ack_total++;
                    pop_cmp("ack", mk(2'd1, i, lcd_op, lcd_data, grant));
                end
                if (done[i]) begin
                    done_cnt[i]++;
                    pop_cmp("done", mk(2'd2, i, lcd_op, lcd_data, grant));
                    chk("done_after_rdy", 32'({r2, r1}), 32'b01);
                end
            end
            if (err) begin
                pop_cmp("err", mk(2'd3, 0, lcd_op, lcd_data, grant));
                chk("err_timing", 32'(en_age), 32'(BT));
            end
            prev_ack = |ack;
            r2 = r1;
            r1 = lcd_rdy;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int a0, n, dbase;
        lock = '0;
        #1;
        chk("reset_outputs", 32'({ack, done, err, grant, lcd_op, lcd_data, lcd_enable}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Round robin from reset: 0,1,2,3,0
        push_op(0, 6'h01, 8'h10, 4'b0000);
        push_op(1, 6'h11, 8'h20, 4'b0000);
        push_op(2, 6'h21, 8'h30, 4'b0000);
        push_op(3, 6'h31, 8'h40, 4'b0000);
        push_op(0, 6'h01, 8'h11, 4'b0000);
        set_req(0, 2, 6'h01, 8'h10);
        set_req(1, 1, 6'h11, 8'h20);
        set_req(2, 1, 6'h21, 8'h30);
        set_req(3, 1, 6'h31, 8'h40);
        wait_empty(400);

        // Single request
        push_op(0, 6'b000010, 8'h41, 4'b0000);
        set_req(0, 1, 6'b000010, 8'h41);
        wait_empty(100);

        // Lock: three ops to 2 while 1 waits
        push_op(2, 6'h05, 8'h50, 4'b0100);
        push_op(2, 6'h05, 8'h51, 4'b0100);
        push_op(2, 6'h05, 8'h52, 4'b0100);
        push_op(1, 6'h06, 8'h60, 4'b0000);
        dbase = done_cnt[2];
        lock[2] = 1'b1;
        set_req(2, 3, 6'h05, 8'h50);
        wait_grant(2, 10);
        set_req(1, 1, 6'h06, 8'h60);
        n = 0;
        while (done_cnt[2] < dbase + 3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("lock_hold_grant", 32'(grant), 32'b0100);
        lock[2] = 1'b0;
        wait_empty(100);

        // Busy timeout, then the next request is still served
        no_busy = 1'b1;
        exp_q.push_back(mk(2'd1, 3, 6'h07, 8'h70, 4'b1000));
        exp_q.push_back(mk(2'd3, 0, 6'h07, 8'h70, 4'b0000));
        set_req(3, 1, 6'h07, 8'h70);
        wait_empty(200);
        no_busy = 1'b0;
        push_op(1, 6'h08, 8'h80, 4'b0000);
        set_req(1, 1, 6'h08, 8'h80);
        wait_empty(100);

        // lcd_rdy low at idle blocks arbitration
        hold_low = 1'b1;
        @(negedge clk);
        a0 = ack_total;
        push_op(3, 6'h09, 8'h90, 4'b0000);
        set_req(3, 1, 6'h09, 8'h90);
        repeat (10) @(negedge clk);
        chk("no_ack_rdy_low", 32'(ack_total - a0), 32'd0);
        chk("no_grant_rdy_low", 32'(grant), 32'd0);
        hold_low = 1'b0;
        @(negedge clk);
        chk("ack_on_rdy", 32'(ack), 32'b1000);
        wait_empty(100);

        // Reset mid-op in WAIT_DONE
        exp_q.push_back(mk(2'd1, 2, 6'h0A, 8'hA5, 4'b0100));
        set_req(2, 1, 6'h0A, 8'hA5);
        n = 0;
        while (rdy_model && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("grant_before_reset", 32'({grant, lcd_op, lcd_data}), 32'({4'b0100, 6'h0A, 8'hA5}));
        #2 rst = 1'b1;
        tgt[2] = got[2];
        #1;
        chk("async_reset_outputs", 32'({ack, done, err, grant, lcd_op, lcd_data, lcd_enable}), 32'd0);
        n = 0;
        while (!rdy_model && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_event_after_reset", 32'(exp_q.size()), 32'd0);

        // After reset requester 0 has top priority over 3
        push_op(0, 6'h0B, 8'hB0, 4'b0000);
        push_op(3, 6'h0C, 8'hC0, 4'b0000);
        set_req(0, 1, 6'h0B, 8'hB0);
        set_req(3, 1, 6'h0C, 8'hC0);
        wait_empty(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
